// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
// Round-robin grant per byte; per packet when UART_ARB_LOCK_EN is defined.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   req_valid_i/_byte_i/_last_i  requester k pending byte at [8k+7:8k]
//   req_ready_o         one-hot combinational accept (IDLE only)
//   tx_byte_o/_valid_o  registered byte and one-cycle start pulse to uart_tx
//   tx_done_i           byte finished on the line
//   grant_o             index of last accepted requester
//   busy_o              high whenever not IDLE
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CCS = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_byte_o,
  output logic                 tx_valid_o,
  input  logic                 tx_done_i,
  output logic [IDX_W-1:0]     grant_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state_q;
  logic [7:0]         tx_byte_q;
  logic               tx_valid_q;
  logic [IDX_W-1:0]   grant_q;
  logic               busy_q;
  logic [7:0]         gap_q;
  logic [IDX_W-1:0]   ptr_q;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic               accept;
  logic [7:0]         win_byte;
  int                 j;

`ifdef UART_ARB_LOCK_EN
  logic               lock_q;
  logic [IDX_W-1:0]   lock_idx_q;
`else
  logic               unused_last;
  assign unused_last = ^req_last_i;
`endif

  // Scan ptr+1, ptr+2, ... so the last winner gets lowest priority.
  always_comb begin
    elig = req_valid_i;
`ifdef UART_ARB_LOCK_EN
    if (lock_q) begin
      elig = req_valid_i & (NUM_REQ'(1) << lock_idx_q);
    end
`endif
    win   = ptr_q;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && elig[IDX_W'(j)]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    accept   = (state_q == IDLE) && found;
    win_byte = req_byte_i[int'(win)*8 +: 8];
  end

  assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
  assign tx_byte_o   = tx_byte_q;
  assign tx_valid_o  = tx_valid_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      gap_q      <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tx_byte_q  <= win_byte;
            grant_q    <= win;
            ptr_q      <= win;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= ~req_last_i[win];
            lock_idx_q <= win;
`endif
          end
        end
        SEND: begin
          tx_valid_q <= 1'b0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            if (GAP_CCS == 0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              gap_q   <= 8'(GAP_CCS - 1);
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
